// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and writeback bypass.
// Optional load-use bubble counter (bubble_count output) enabled by defining ID_EX_PERF_EN.
module id_ex_stage #(
  parameter int ALU_OP_W   = 4,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [31:0]           pc,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [31:0]           rs1_data,
  input  logic [31:0]           rs2_data,
  input  logic [31:0]           imm,
  input  logic [ALU_OP_W-1:0]   alu_op,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  alu_src_imm,
  input  logic                  wb_write_enable,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [31:0]           wb_write_data,
  output logic                  ex_valid,
  output logic [31:0]           ex_pc,
  output logic [REG_ADDR_W-1:0] ex_rs1_addr,
  output logic [REG_ADDR_W-1:0] ex_rs2_addr,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic [31:0]           ex_rs1_data,
  output logic [31:0]           ex_rs2_data,
  output logic [31:0]           ex_imm,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_alu_src_imm,
`ifdef ID_EX_PERF_EN
  output logic [31:0]           bubble_count,
`endif
  output logic                  load_use_stall
);

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2
  } action_t;

  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = '0;

  action_t                 action;
  logic                    valid_reg;
  logic [31:0]             pc_reg;
  logic [REG_ADDR_W-1:0]   rs1_addr_reg;
  logic [REG_ADDR_W-1:0]   rs2_addr_reg;
  logic [REG_ADDR_W-1:0]   rd_addr_reg;
  logic [31:0]             imm_reg;
  logic [ALU_OP_W-1:0]     alu_op_reg;
  logic                    reg_write_reg;
  logic                    mem_read_reg;
  logic                    mem_write_reg;
  logic                    alu_src_imm_reg;

  logic [REG_ADDR_W-1:0]   src_addr [2];
  logic [REG_ADDR_W-1:0]   held_addr [2];
  logic [31:0]             src_data [2];
  logic [31:0]             opnd_data [2];

  // Hazard against the instruction currently in EX; independent of flush.
  always_comb begin
    load_use_stall = in_valid && valid_reg && mem_read_reg &&
                     (rd_addr_reg != ZERO_ADDR) &&
                     ((rd_addr_reg == rs1_addr) || (rd_addr_reg == rs2_addr));
  end

  always_comb begin
    action = ACT_LOAD;
    if (flush) begin
      action = ACT_BUBBLE;
    end else if (stall) begin
      action = ACT_HOLD;
    end else if (load_use_stall) begin
      action = ACT_BUBBLE;
    end
  end

  // Bubbles only clear the qualifying bits; payload fields are left as-is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg       <= 1'b0;
      pc_reg          <= '0;
      rs1_addr_reg    <= '0;
      rs2_addr_reg    <= '0;
      rd_addr_reg     <= '0;
      imm_reg         <= '0;
      alu_op_reg      <= '0;
      reg_write_reg   <= 1'b0;
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
      alu_src_imm_reg <= 1'b0;
    end else begin
      case (action)
        ACT_BUBBLE: begin
          valid_reg     <= 1'b0;
          reg_write_reg <= 1'b0;
          mem_read_reg  <= 1'b0;
          mem_write_reg <= 1'b0;
        end
        ACT_LOAD: begin
          valid_reg       <= in_valid;
          pc_reg          <= pc;
          rs1_addr_reg    <= rs1_addr;
          rs2_addr_reg    <= rs2_addr;
          rd_addr_reg     <= rd_addr;
          imm_reg         <= imm;
          alu_op_reg      <= alu_op;
          reg_write_reg   <= reg_write && in_valid;
          mem_read_reg    <= mem_read && in_valid;
          mem_write_reg   <= mem_write && in_valid;
          alu_src_imm_reg <= alu_src_imm && in_valid;
        end
        default: begin
        end
      endcase
    end
  end

  assign src_addr[0]  = rs1_addr;
  assign src_addr[1]  = rs2_addr;
  assign src_data[0]  = rs1_data;
  assign src_data[1]  = rs2_data;
  assign held_addr[0] = rs1_addr_reg;
  assign held_addr[1] = rs2_addr_reg;

  // Each source operand picks up a same-cycle writeback, on capture or while held.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
      logic [31:0] data_reg;
      logic        hit_load;
      logic        hit_hold;

      always_comb begin
        hit_load = wb_write_enable && (wb_rd_addr != ZERO_ADDR) &&
                   (wb_rd_addr == src_addr[gi]);
        hit_hold = wb_write_enable && (wb_rd_addr != ZERO_ADDR) &&
                   (wb_rd_addr == held_addr[gi]);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg <= '0;
        end else if (action == ACT_LOAD) begin
          data_reg <= hit_load ? wb_write_data : src_data[gi];
        end else if (action == ACT_HOLD && hit_hold) begin
          data_reg <= wb_write_data;
        end
      end

      assign opnd_data[gi] = data_reg;
    end
  endgenerate

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_count_reg;

  // Counts only hazard bubbles: flush and stall take priority and are excluded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count_reg <= '0;
    end else if (!flush && !stall && load_use_stall) begin
      bubble_count_reg <= bubble_count_reg + 32'd1;
    end
  end

  assign bubble_count = bubble_count_reg;
`endif

  assign ex_valid       = valid_reg;
  assign ex_pc          = pc_reg;
  assign ex_rs1_addr    = rs1_addr_reg;
  assign ex_rs2_addr    = rs2_addr_reg;
  assign ex_rd_addr     = rd_addr_reg;
  assign ex_rs1_data    = opnd_data[0];
  assign ex_rs2_data    = opnd_data[1];
  assign ex_imm         = imm_reg;
  assign ex_alu_op      = alu_op_reg;
  assign ex_reg_write   = reg_write_reg;
  assign ex_mem_read    = mem_read_reg;
  assign ex_mem_write   = mem_write_reg;
  assign ex_alu_src_imm = alu_src_imm_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed vector table, reset corner case, random run vs model.
module tb_id_ex_stage;
  localparam int AW = 5;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, stall, flush;
  logic [31:0]   pc;
  logic [AW-1:0] rs1_addr, rs2_addr, rd_addr;
  logic [31:0]   rs1_data, rs2_data, imm;
  logic [OW-1:0] alu_op;
  logic          reg_write, mem_read, mem_write, alu_src_imm;
  logic          wb_write_enable;
  logic [AW-1:0] wb_rd_addr;
  logic [31:0]   wb_write_data;
  logic          ex_valid;
  logic [31:0]   ex_pc;
  logic [AW-1:0] ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [31:0]   ex_rs1_data, ex_rs2_data, ex_imm;
  logic [OW-1:0] ex_alu_op;
  logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src_imm;
  logic          load_use_stall;
`ifdef ID_EX_PERF_EN
  logic [31:0]   bubble_count;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.ALU_OP_W(OW), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .alu_op(alu_op),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src_imm(alu_src_imm), .wb_write_enable(wb_write_enable),
    .wb_rd_addr(wb_rd_addr), .wb_write_data(wb_write_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_addr(ex_rs1_addr),
    .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_alu_op(ex_alu_op), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src_imm(ex_alu_src_imm),
`ifdef ID_EX_PERF_EN
    .bubble_count(bubble_count),
`endif
    .load_use_stall(load_use_stall)
  );

  typedef struct {
    bit v, st, fl;
    logic [31:0] pc;
    logic [AW-1:0] a1, a2, rd;
    logic [31:0] d1, d2, imm;
    logic [OW-1:0] op;
    bit mr, rw, mw, as;
    bit we;
    logic [AW-1:0] wa;
    logic [31:0] wd;
  } in_t;

  typedef struct {
    bit valid;
    logic [31:0] pc, d1, d2, imm;
    logic [AW-1:0] a1, a2, rd;
    logic [OW-1:0] op;
    bit rw, mr, mw, as;
  } ex_t;

  typedef struct {
    in_t i;
    bit e_lus;
    bit e_valid;
    logic [31:0] e_pc, e_d1, e_d2;
  } vec_t;

  int checks = 0;
  int errors = 0;
  ex_t m;
  int unsigned m_bubbles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic in_t mkin(bit v, bit st, bit fl, logic [31:0] p, int a1, int a2, int rd,
                               logic [31:0] d1, logic [31:0] d2, logic [31:0] im, int op,
                               bit mr, bit rw, bit we, int wa, logic [31:0] wd);
    in_t x;
    x.v = v; x.st = st; x.fl = fl; x.pc = p;
    x.a1 = AW'(a1); x.a2 = AW'(a2); x.rd = AW'(rd);
    x.d1 = d1; x.d2 = d2; x.imm = im; x.op = OW'(op);
    x.mr = mr; x.rw = rw; x.mw = 1'b0; x.as = 1'b0;
    x.we = we; x.wa = AW'(wa); x.wd = wd;
    return x;
  endfunction

  function automatic vec_t mkv(in_t i, bit lus, bit ev, logic [31:0] p, logic [31:0] d1, logic [31:0] d2);
    vec_t r;
    r.i = i; r.e_lus = lus; r.e_valid = ev; r.e_pc = p; r.e_d1 = d1; r.e_d2 = d2;
    return r;
  endfunction

  task automatic drive(input in_t x);
    in_valid = x.v; stall = x.st; flush = x.fl; pc = x.pc;
    rs1_addr = x.a1; rs2_addr = x.a2; rd_addr = x.rd;
    rs1_data = x.d1; rs2_data = x.d2; imm = x.imm; alu_op = x.op;
    mem_read = x.mr; reg_write = x.rw; mem_write = x.mw; alu_src_imm = x.as;
    wb_write_enable = x.we; wb_rd_addr = x.wa; wb_write_data = x.wd;
  endtask

  function automatic bit model_lus(in_t x);
    return x.v && m.valid && m.mr && (m.rd != 0) && (m.rd == x.a1 || m.rd == x.a2);
  endfunction

  function automatic logic [31:0] wb_pick(in_t x, logic [AW-1:0] a, logic [31:0] d);
    return (x.we && x.wa != 0 && x.wa == a) ? x.wd : d;
  endfunction

  task automatic model_step(input in_t x);
    bit lus;
    lus = model_lus(x);
    if (x.fl || (!x.st && lus)) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0;
      if (!x.fl) m_bubbles++;
    end else if (x.st) begin
      m.d1 = wb_pick(x, m.a1, m.d1);
      m.d2 = wb_pick(x, m.a2, m.d2);
    end else begin
      m.valid = x.v; m.pc = x.pc; m.a1 = x.a1; m.a2 = x.a2; m.rd = x.rd;
      m.d1 = wb_pick(x, x.a1, x.d1); m.d2 = wb_pick(x, x.a2, x.d2);
      m.imm = x.imm; m.op = x.op;
      m.rw = x.rw && x.v; m.mr = x.mr && x.v; m.mw = x.mw && x.v; m.as = x.as && x.v;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m.valid));
    chk({tag, ".ctrl"}, 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'({m.rw, m.mr, m.mw}));
    if (m.valid) begin
      chk({tag, ".pc"}, ex_pc, m.pc);
      chk({tag, ".addrs"}, 32'({ex_rs1_addr, ex_rs2_addr, ex_rd_addr}), 32'({m.a1, m.a2, m.rd}));
      chk({tag, ".rs1_data"}, ex_rs1_data, m.d1);
      chk({tag, ".rs2_data"}, ex_rs2_data, m.d2);
      chk({tag, ".imm"}, ex_imm, m.imm);
      chk({tag, ".op_src"}, 32'({ex_alu_op, ex_alu_src_imm}), 32'({m.op, m.as}));
    end
`ifdef ID_EX_PERF_EN
    chk({tag, ".bubble_count"}, bubble_count, m_bubbles);
`endif
  endtask

  // Starts and ends on a falling edge.
  task automatic run_cycle(input in_t x, input string tag);
    drive(x);
    #1;
    chk({tag, ".load_use_stall"}, 32'(load_use_stall), 32'(model_lus(x)));
    @(posedge clk);
    model_step(x);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  vec_t vecs [14];
  in_t  x;

  initial begin
    vecs[0]  = mkv(mkin(1,0,0,32'h100,3,0,1,32'h11,0,32'h8,2,0,1,0,0,0), 0, 1, 32'h100, 32'h11, 0);
    vecs[1]  = mkv(mkin(1,0,0,32'h104,5,0,2,32'hAAAA,0,0,0,0,1,1,5,32'h1234), 0, 1, 32'h104, 32'h1234, 0);
    vecs[2]  = mkv(mkin(1,0,0,32'h108,5,0,2,32'hAAAA,0,0,0,0,1,1,0,32'h1234), 0, 1, 32'h108, 32'hAAAA, 0);
    vecs[3]  = mkv(mkin(1,0,0,32'h10C,1,2,7,0,0,32'h4,0,1,1,0,0,0), 0, 1, 32'h10C, 0, 0);
    vecs[4]  = mkv(mkin(1,0,0,32'h110,6,7,8,32'h66,32'h55,0,0,0,1,0,0,0), 1, 0, 0, 0, 0);
    vecs[5]  = mkv(mkin(1,0,0,32'h110,6,7,8,32'h66,32'h55,0,0,0,1,0,0,0), 0, 1, 32'h110, 32'h66, 32'h55);
    vecs[6]  = mkv(mkin(1,0,0,32'h200,0,9,3,0,32'h99,32'h40,1,0,1,0,0,0), 0, 1, 32'h200, 0, 32'h99);
    vecs[7]  = mkv(mkin(1,1,0,32'h300,9,9,9,32'h1,32'h2,0,0,1,1,0,0,0), 0, 1, 32'h200, 0, 32'h99);
    vecs[8]  = mkv(mkin(1,1,0,32'h300,9,9,9,32'h1,32'h2,0,0,1,1,1,9,32'hBEEF), 0, 1, 32'h200, 0, 32'hBEEF);
    vecs[9]  = mkv(mkin(1,1,0,32'h300,9,9,9,32'h1,32'h2,0,0,1,1,0,0,0), 0, 1, 32'h200, 0, 32'hBEEF);
    vecs[10] = mkv(mkin(1,1,1,32'h400,1,1,1,32'h1,32'h2,0,0,0,1,0,0,0), 0, 0, 0, 0, 0);
    vecs[11] = mkv(mkin(1,0,0,32'h500,0,0,4,0,0,0,0,1,1,0,0,0), 0, 1, 32'h500, 0, 0);
    vecs[12] = mkv(mkin(1,0,1,32'h504,4,0,1,32'h7,0,0,0,0,1,0,0,0), 1, 0, 0, 0, 0);
    vecs[13] = mkv(mkin(1,0,0,32'h508,4,0,1,32'h7,0,0,0,0,1,0,0,0), 0, 1, 32'h508, 32'h7, 0);

    m = '{default: 0};
    m_bubbles = 0;
    rst = 1'b1;
    drive(mkin(1,0,0,32'hFFFF,1,1,1,32'h5,32'h5,32'h5,3,1,1,0,0,0));
    #1;
    chk("reset.valid", 32'(ex_valid), 0);
    chk("reset.pc", ex_pc, 0);
    chk("reset.data", ex_rs1_data | ex_rs2_data | ex_imm, 0);
    chk("reset.fields", 32'({ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_alu_op}), 0);
    chk("reset.ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src_imm}), 0);
    chk("reset.load_use_stall", 32'(load_use_stall), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 14; k++) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      run_cycle(vecs[k].i, tag);
      chk({tag, ".exp_valid"}, 32'(ex_valid), 32'(vecs[k].e_valid));
      if (vecs[k].e_valid) begin
        chk({tag, ".exp_pc"}, ex_pc, vecs[k].e_pc);
        chk({tag, ".exp_rs1"}, ex_rs1_data, vecs[k].e_d1);
        chk({tag, ".exp_rs2"}, ex_rs2_data, vecs[k].e_d2);
      end
      if (k == 4 || k == 12) chk({tag, ".table_lus_seen"}, 32'(m_bubbles), 1);
    end
`ifdef ID_EX_PERF_EN
    chk("table.bubble_count", bubble_count, 1);
`endif

    // Reset asserted in the middle of a stall with a pending load-use hazard.
    run_cycle(mkin(1,0,0,32'h600,0,0,2,0,0,0,1,1,1,0,0,0), "rst_seq.lw");
    x = mkin(1,1,0,32'h604,2,3,5,32'h1,32'h2,0,0,0,1,0,0,0);
    drive(x);
    #1;
    chk("rst_seq.lus_before", 32'(load_use_stall), 1);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_seq.valid", 32'(ex_valid), 0);
    chk("rst_seq.pc", ex_pc, 0);
    chk("rst_seq.rd", 32'(ex_rd_addr), 0);
    chk("rst_seq.ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 0);
    chk("rst_seq.lus", 32'(load_use_stall), 0);
`ifdef ID_EX_PERF_EN
    chk("rst_seq.bubble_count", bubble_count, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    m = '{default: 0};
    m_bubbles = 0;
    run_cycle(mkin(1,0,0,32'h700,2,3,5,32'h21,32'h22,32'h9,4,0,1,0,0,0), "rst_seq.first_load");
    chk("rst_seq.first_pc", ex_pc, 32'h700);

    for (int n = 0; n < 400; n++) begin
      x.v  = ($urandom_range(0, 9) != 0);
      x.st = ($urandom_range(0, 6) == 0);
      x.fl = ($urandom_range(0, 11) == 0);
      x.pc = $urandom;
      x.a1 = AW'($urandom_range(0, 7));
      x.a2 = AW'($urandom_range(0, 7));
      x.rd = AW'($urandom_range(0, 7));
      x.d1 = $urandom; x.d2 = $urandom; x.imm = $urandom;
      x.op = OW'($urandom_range(0, 15));
      x.mr = ($urandom_range(0, 2) == 0);
      x.rw = $urandom_range(0, 1) == 1;
      x.mw = ($urandom_range(0, 4) == 0);
      x.as = $urandom_range(0, 1) == 1;
      x.we = $urandom_range(0, 1) == 1;
      x.wa = AW'($urandom_range(0, 7));
      x.wd = $urandom;
      run_cycle(x, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter ALU_OP_W, default 4, width of ALU operation code.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register address width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-004 SHALL have inputs: in_valid 1 (decode slot holds an instruction); stall 1 (freeze stage); flush 1 (discard stage contents); pc 32; rs1_addr, rs2_addr, rd_addr REG_ADDR_W; rs1_data, rs2_data 32 (register file read data); imm 32; alu_op ALU_OP_W; reg_write, mem_read, mem_write, alu_src_imm 1 each.
REQ-005 SHALL have writeback inputs: wb_write_enable 1, wb_rd_addr REG_ADDR_W, wb_write_data 32 (same values driven to the register file write port).
REQ-006 SHALL have outputs: ex_valid 1; ex_pc 32; ex_rs1_addr, ex_rs2_addr, ex_rd_addr REG_ADDR_W; ex_rs1_data, ex_rs2_data 32; ex_imm 32; ex_alu_op ALU_OP_W; ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src_imm 1 each; load_use_stall 1 (combinational request to hold IF/ID).

Function
REQ-007 SHALL compute load_use_stall = in_valid & ex_valid & ex_mem_read & (ex_rd_addr != 0) & (ex_rd_addr == rs1_addr | ex_rd_addr == rs2_addr), combinationally, same cycle.
REQ-008 SHALL update on each rising clk with priority: flush > stall > load_use_stall > load.
REQ-009 Flush: SHALL write a bubble next edge: ex_valid=0, ex_reg_write=ex_mem_read=ex_mem_write=0; other fields may retain or zero (bench ignores them when ex_valid=0).
REQ-010 Stall (no flush): SHALL hold all outputs, except REQ-013 operand refresh.
REQ-011 Load-use (no flush, no stall): SHALL write a bubble as in REQ-009; upstream holds decode, so the same instruction is presented again next cycle.
REQ-012 Load: SHALL capture all decode inputs one cycle later (latency 1); ex_valid <= in_valid; control bits <= input control bits gated by in_valid.
REQ-013 Write-before-read bypass: on load, captured rs1 = wb_write_data when wb_write_enable & wb_rd_addr != 0 & wb_rd_addr == rs1_addr, else rs1_data; same for rs2. On hold, ex_rs1_data/ex_rs2_data SHALL be refreshed with wb_write_data under the same match against ex_rs1_addr/ex_rs2_addr.
REQ-014 Address 0 SHALL never bypass; rs data for x0 passes through unchanged (register file returns 0).
REQ-015 Simultaneous flush and load_use_stall SHALL produce one bubble; load_use_stall remains asserted combinationally regardless of flush.
REQ-016 No combinational path from any input to any ex_* output.

Reset
REQ-017 While rst=1, asynchronously: ex_valid=0, all ex_* data/address/imm/alu_op=0, all control bits=0; load_use_stall therefore 0.
REQ-018 Reset mid-stall or mid-bubble SHALL discard the held instruction; first edge after rst deassertion follows REQ-008 normally.

Configuration
REQ-019 Macro ID_EX_PERF_EN: when defined, SHALL add output bubble_count 32, incremented by 1 on each edge where a load-use bubble (REQ-011) is inserted, wrapping 0xFFFFFFFF->0, reset to 0; flush and stall cycles not counted.
REQ-020 Without ID_EX_PERF_EN the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-021 Load: in_valid=1, pc=0x100, rs1_addr=3, rs1_data=0x11, imm=0x8, alu_op=2, no WB -> next cycle ex_valid=1, ex_pc=0x100, ex_rs1_data=0x11, ex_imm=0x8, ex_alu_op=2.
REQ-022 Bypass: rs1_addr=5, rs1_data=0xAAAA, wb_write_enable=1, wb_rd_addr=5, wb_write_data=0x1234 -> ex_rs1_data=0x1234; repeat with wb_rd_addr=0 -> ex_rs1_data=rs1_data.
REQ-023 Load-use: EX holds lw (mem_read=1, rd=7), decode rs2_addr=7 -> load_use_stall=1 same cycle, next cycle ex_valid=0; re-presented instruction loads following cycle; bubble_count=1 with ID_EX_PERF_EN.
REQ-024 Stall with refresh: stall=1 for 3 cycles, ex_rs2_addr=9, WB writes x9=0xBEEF in cycle 2 -> all outputs held except ex_rs2_data=0xBEEF.
REQ-025 Priority/reset: flush=1 and stall=1 together -> ex_valid=0 next cycle; rst pulse mid-stall -> all outputs 0 immediately, bubble_count=0.
